// File: rtl/pipe_pkg.sv
// Shared EX/MEM pipeline types: control bundle, default-width payload and bubble-gating helper.
package pipe_pkg;

    localparam int unsigned PIPE_DATA_W = 32;
    localparam int unsigned PIPE_REG_AW = 5;

    typedef struct packed {
        logic MemtoReg;
        logic RegWrite;
        logic MemWrite;
        logic MemRead;
    } ex_mem_ctrl_t;

    localparam ex_mem_ctrl_t PIPE_CTRL_NOP = '0;

    typedef struct packed {
        ex_mem_ctrl_t                  ctrl;
        logic [PIPE_DATA_W-1:0]        aluResult;
        logic [PIPE_DATA_W-1:0]        storeData;
        logic [PIPE_REG_AW-1:0]        writeReg;
    } ex_mem_payload_t;

    // A bubble must never write memory or the register file.
    function automatic ex_mem_ctrl_t gateCtrl(input ex_mem_ctrl_t c, input logic valid);
        ex_mem_ctrl_t g;
        g          = c;
        g.RegWrite = c.RegWrite & valid;
        g.MemWrite = c.MemWrite & valid;
        g.MemRead  = c.MemRead  & valid;
        return g;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter shared by the stage performance monitors.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register with valid/ready handshake, flush, bubble gating and stall counter.
// Define EX_MEM_SKID_EN for a 2-entry skid buffer with a registered in_ready_o.
module ex_mem_pipe
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic              MemtoReg_i,
    input  logic              RegWrite_i,
    input  logic              MemWrite_i,
    input  logic              MemRead_i,
    input  logic [DATA_W-1:0] ALU_result_i,
    input  logic [DATA_W-1:0] Mem_Write_Data_i,
    input  logic [REG_AW-1:0] Write_register_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              MemtoReg_o,
    output logic              RegWrite_o,
    output logic              MemWrite_o,
    output logic              MemRead_o,
    output logic [DATA_W-1:0] ALU_result_o,
    output logic [DATA_W-1:0] Mem_Write_Data_o,
    output logic [REG_AW-1:0] Write_register_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef struct packed {
        ex_mem_ctrl_t      ctrl;
        logic [DATA_W-1:0] aluResult;
        logic [DATA_W-1:0] storeData;
        logic [REG_AW-1:0] writeReg;
    } payload_t;

    payload_t     inBeat;
    payload_t     mainQ;
    logic         valid_q;
    logic         accept;
    logic         consume;
    ex_mem_ctrl_t outCtrl;

    always_comb begin
        inBeat               = '0;
        inBeat.ctrl.MemtoReg = MemtoReg_i;
        inBeat.ctrl.RegWrite = RegWrite_i;
        inBeat.ctrl.MemWrite = MemWrite_i;
        inBeat.ctrl.MemRead  = MemRead_i;
        inBeat.aluResult     = ALU_result_i;
        inBeat.storeData     = Mem_Write_Data_i;
        inBeat.writeReg      = Write_register_i;
    end

    assign accept  = in_valid_i & in_ready_o;
    assign consume = valid_q & out_ready_i;

`ifdef EX_MEM_SKID_EN
    payload_t skidQ;
    logic     skid_valid_q;

    assign in_ready_o = ~skid_valid_q;

    // Skid drains into main first so ordering stays FIFO.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q      <= 1'b0;
            skid_valid_q <= 1'b0;
            mainQ        <= '0;
            skidQ        <= '0;
        end else if (flush_i) begin
            valid_q      <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (!valid_q || consume) begin
            if (skid_valid_q) begin
                mainQ        <= skidQ;
                valid_q      <= 1'b1;
                skid_valid_q <= accept;
                if (accept) begin
                    skidQ <= inBeat;
                end
            end else begin
                valid_q <= accept;
                if (accept) begin
                    mainQ <= inBeat;
                end
            end
        end else if (accept) begin
            skidQ        <= inBeat;
            skid_valid_q <= 1'b1;
        end
    end
`else
    assign in_ready_o = ~valid_q | out_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            mainQ   <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (!valid_q || consume) begin
            valid_q <= accept;
            if (accept) begin
                mainQ <= inBeat;
            end
        end
    end
`endif

    assign outCtrl          = gateCtrl(mainQ.ctrl, valid_q);
    assign out_valid_o      = valid_q;
    assign MemtoReg_o       = mainQ.ctrl.MemtoReg;
    assign RegWrite_o       = outCtrl.RegWrite;
    assign MemWrite_o       = outCtrl.MemWrite;
    assign MemRead_o        = outCtrl.MemRead;
    assign ALU_result_o     = mainQ.aluResult;
    assign Mem_Write_Data_o = mainQ.storeData;
    assign Write_register_o = mainQ.writeReg;

    sat_counter #(
        .W(CNT_W)
    ) uStallCnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .clear (1'b0),
        .inc   (valid_q & ~out_ready_i),
        .count (stall_cnt_o)
    );

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Scoreboard bench for ex_mem_pipe: directed beats, stall, flush and counter saturation.
module tb_ex_mem_pipe;

`ifdef EX_MEM_SKID_EN
    localparam logic SKID = 1'b1;
`else
    localparam logic SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, inValid, outReady;
    logic        m2r, rw, mw, mr;
    logic [31:0] alu, wd;
    logic [4:0]  wr;

    logic        inReady, outValid, m2rO, rwO, mwO, mrO;
    logic [31:0] aluO, wdO;
    logic [4:0]  wrO;
    logic [15:0] stallCnt;

    logic        inReady3, outValid3, m2rO3, rwO3, mwO3, mrO3;
    logic [31:0] aluO3, wdO3;
    logic [4:0]  wrO3;
    logic [2:0]  stallCnt3;

    always #5 clk = ~clk;

    ex_mem_pipe uDut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(inValid), .in_ready_o(inReady),
        .MemtoReg_i(m2r), .RegWrite_i(rw), .MemWrite_i(mw), .MemRead_i(mr),
        .ALU_result_i(alu), .Mem_Write_Data_i(wd), .Write_register_i(wr),
        .out_valid_o(outValid), .out_ready_i(outReady),
        .MemtoReg_o(m2rO), .RegWrite_o(rwO), .MemWrite_o(mwO), .MemRead_o(mrO),
        .ALU_result_o(aluO), .Mem_Write_Data_o(wdO), .Write_register_o(wrO),
        .stall_cnt_o(stallCnt)
    );

    ex_mem_pipe #(.CNT_W(3)) uDut3 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(inValid), .in_ready_o(inReady3),
        .MemtoReg_i(m2r), .RegWrite_i(rw), .MemWrite_i(mw), .MemRead_i(mr),
        .ALU_result_i(alu), .Mem_Write_Data_i(wd), .Write_register_i(wr),
        .out_valid_o(outValid3), .out_ready_i(outReady),
        .MemtoReg_o(m2rO3), .RegWrite_o(rwO3), .MemWrite_o(mwO3), .MemRead_o(mrO3),
        .ALU_result_o(aluO3), .Mem_Write_Data_o(wdO3), .Write_register_o(wrO3),
        .stall_cnt_o(stallCnt3)
    );

    typedef struct {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  wr;
        logic [3:0]  ctrl;
        int          cyc;
    } beat_t;

    beat_t expQ[$];
    int    total = 0;
    int    bad = 0;
    int    popCnt = 0;
    int    cyc = 0;
    logic  chkLat = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop/compare on consume, then record accepted beats or squash on flush.
    always @(negedge clk) begin
        beat_t b;
        if (!rst) begin
            if (outValid && outReady) begin
                if (expQ.size() == 0) begin
                    chk("unexpected_output", 32'(aluO), 32'hdead_beef);
                end else begin
                    b = expQ.pop_front();
                    popCnt++;
                    chk("out_alu", aluO, b.alu);
                    chk("out_wd", wdO, b.wd);
                    chk("out_wr", 32'(wrO), 32'(b.wr));
                    chk("out_ctrl", 32'({m2rO, rwO, mwO, mrO}), 32'(b.ctrl));
                    if (chkLat) chk("latency", 32'(cyc - b.cyc), 32'd1);
                end
            end
            if (flush) begin
                expQ.delete();
            end else if (inValid && inReady) begin
                b.alu  = alu;
                b.wd   = wd;
                b.wr   = wr;
                b.ctrl = {m2r, rw, mw, mr};
                b.cyc  = cyc;
                expQ.push_back(b);
            end
        end
    end

    // Present one beat and hold it until accepted; returns at posedge+1 with in_valid low.
    task automatic send(input logic [31:0] a, input logic [3:0] c, input logic [4:0] r);
        logic done;
        done = 1'b0;
        {m2r, rw, mw, mr} = c;
        alu = a;
        wd = ~a;
        wr = r;
        inValid = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (inReady) done = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) chk("send_timeout", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; flush = 1'b0; inValid = 1'b1; outReady = 1'b1;
        {m2r, rw, mw, mr} = 4'hf; alu = 32'h99; wd = 32'h55; wr = 5'd3;

        // Reset with a valid beat presented
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(outValid), 32'd0);
        chk("rst_ctrl", 32'({m2rO, rwO, mwO, mrO}), 32'd0);
        chk("rst_alu", aluO, 32'd0);
        chk("rst_wd", wdO, 32'd0);
        chk("rst_wr", 32'(wrO), 32'd0);
        chk("rst_stall", 32'(stallCnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        inValid = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(inReady), 32'd1);
        chk("post_rst_valid", 32'(outValid), 32'd0);

        // Streaming at full throughput
        @(posedge clk);
        #1;
        chkLat = 1'b1;
        for (int i = 1; i <= 8; i++) send(32'(i), 4'b0100, 5'(i));
        idle(3);
        chkLat = 1'b0;
        chk("stream_count", 32'(popCnt), 32'd8);
        chk("stream_stall", 32'(stallCnt), 32'd0);

        // Back-pressure: A held, B queued, stall counted, then A before B
        fork
            begin
                send(32'h10, 4'b0010, 5'd10);
                send(32'h20, 4'b0101, 5'd20);
            end
            begin
                outReady = 1'b0;
                repeat (4) @(posedge clk);
                @(negedge clk);
                chk("hold_alu", aluO, 32'h10);
                chk("hold_memwrite", 32'(mwO), 32'd1);
                chk("hold_valid", 32'(outValid), 32'd1);
                chk("hold_ready", 32'(inReady), 32'd0);
                chk("hold_stall", 32'(stallCnt), 32'd3);
                chk("hold_stall3", 32'(stallCnt3), 32'd3);
                @(posedge clk);
                #1;
                outReady = 1'b1;
                @(negedge clk);
                @(negedge clk);
                chk("drain_alu", aluO, 32'h20);
                chk("drain_ready", 32'(inReady), 32'd1);
                chk("drain_stall", 32'(stallCnt), 32'd4);
            end
        join
        idle(2);
        chk("bp_count", 32'(popCnt), 32'd10);

        // Flush with the stage full: nothing held may appear
        outReady = 1'b0;
        {m2r, rw, mw, mr} = 4'b0010; alu = 32'h30; wd = 32'h3; wr = 5'd30; inValid = 1'b1;
        @(posedge clk);
        #1;
        alu = 32'h40; wd = 32'h4; wr = 5'd31;
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        inValid = 1'b0;
        @(negedge clk);
        chk("flush_valid", 32'(outValid), 32'd0);
        chk("flush_memwrite", 32'(mwO), 32'd0);
        chk("flush_ready", 32'(inReady), 32'd1);

        // Beat presented during flush is dropped
        @(posedge clk);
        #1;
        outReady = 1'b1;
        alu = 32'h50; inValid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        inValid = 1'b0;
        @(negedge clk);
        chk("flush_drop_valid", 32'(outValid), 32'd0);
        chk("flush_drop_regwrite", 32'(rwO), 32'd0);
        idle(3);
        chk("flush_stall", 32'(stallCnt), 32'd6);

        // Long stall: 16-bit counter keeps counting, 3-bit counter saturates
        outReady = 1'b0;
        send(32'h70, 4'b1100, 5'd7);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("sat_stall", 32'(stallCnt), 32'd16);
        chk("sat_stall3", 32'(stallCnt3), 32'd7);
        chk("sat_alu", aluO, 32'h70);
        chk("sat_ctrl", 32'({m2rO, rwO, mwO, mrO}), 32'b1100);
        chk("full_ready", 32'(inReady), 32'(SKID));
        @(posedge clk);
        #1;
        outReady = 1'b1;
        #1;
        chk("release_ready", 32'(inReady), 32'd1);
        idle(2);
        @(negedge clk);
        chk("final_stall", 32'(stallCnt), 32'd17);
        chk("final_stall3", 32'(stallCnt3), 32'd7);
        chk("final_count", 32'(popCnt), 32'd11);
        chk("final_queue", 32'(expQ.size()), 32'd0);
        chk("final_valid", 32'(outValid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
